// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: M-extension funct3 codes, mul/div FSM states and helpers.
package pipeline_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Two's-complement negate of an XLEN-wide value.
  function automatic logic [XLEN-1:0] negate32(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // Two's-complement negate of a double-width product.
  function automatic logic [2*XLEN-1:0] negate64(input logic [2*XLEN-1:0] x);
    return ~x + (2*XLEN)'(1);
  endfunction

  // Magnitude of an operand that is negative when isNeg is set.
  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] x, input logic isNeg);
    return isNeg ? negate32(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_stall_unit.sv
// Iterative RV32M multiply/divide unit for EX; holds the pipeline via StallReqE while busy.
module muldiv_stall_unit
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StartE,
  input  logic [2:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            KillE,
  output logic            StallReqE,
  output logic            DoneE,
  output logic [XLEN-1:0] MulDivResultE
);

  muldiv_state_t     state;
  logic [CNT_W-1:0]  count;
  logic [2:0]        funct;
  logic [XLEN-1:0]   opA;
  logic [XLEN-1:0]   opB;
  logic [2*XLEN-1:0] acc;
  logic              signA;
  logic              signB;
  logic [XLEN-1:0]   result;

  logic              isDivIn;
  logic              aSignedIn;
  logic              bSignedIn;
  logic              sA;
  logic              sB;
  logic [XLEN-1:0]   magA;
  logic [XLEN-1:0]   magB;
  logic              divZero;
  logic              divOvf;
  logic [XLEN-1:0]   specialRes;

  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift;
  logic              divGe;
  logic [XLEN-1:0]   divDiff;
  logic [2*XLEN-1:0] accNext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   finalRes;

  // Decode the incoming op: operand signedness, magnitudes and divide special cases.
  always_comb begin
    isDivIn    = FunctE[2];
    aSignedIn  = isDivIn ? ~FunctE[0] : (FunctE != F3_MULHU);
    bSignedIn  = isDivIn ? ~FunctE[0] : ~FunctE[1];
    sA         = aSignedIn & SrcAE[XLEN-1];
    sB         = bSignedIn & SrcBE[XLEN-1];
    magA       = absVal(SrcAE, sA);
    magB       = absVal(SrcBE, sB);
    divZero    = isDivIn & (SrcBE == '0);
    divOvf     = isDivIn & ~FunctE[0] & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
    if (divZero) specialRes = FunctE[1] ? SrcAE : '1;
    else         specialRes = FunctE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One shift-add or restoring-divide step, plus sign fix-up of the would-be final value.
  always_comb begin
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opA} : '0);
    divShift = acc[2*XLEN-1:XLEN-1];
    divGe    = divShift >= {1'b0, opB};
    divDiff  = divShift[XLEN-1:0] - opB;
    if (funct[2]) begin
      if (divGe) accNext = {divDiff, acc[XLEN-2:0], 1'b1};
      else       accNext = {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      accNext = {mulSum, acc[XLEN-1:1]};
    end
    prod = (signA ^ signB) ? negate64(accNext) : accNext;
    quo  = accNext[XLEN-1:0];
    rem  = accNext[2*XLEN-1:XLEN];
    if (funct[2]) begin
      if (funct[1]) finalRes = signA ? negate32(rem) : rem;
      else          finalRes = (signA ^ signB) ? negate32(quo) : quo;
    end else begin
      finalRes = (funct == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // FSM and datapath registers; KillE abandons the op without touching the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      funct  <= '0;
      opA    <= '0;
      opB    <= '0;
      acc    <= '0;
      signA  <= 1'b0;
      signB  <= 1'b0;
      result <= '0;
    end else if (KillE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (StartE) begin
            funct <= FunctE;
            opA   <= magA;
            opB   <= magB;
            signA <= sA;
            signB <= sB;
            if (divZero || divOvf) begin
              result <= specialRes;
              state  <= DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, (isDivIn ? magA : magB)};
              count <= CNT_W'(XLEN - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= accNext;
          count <= count - CNT_W'(1);
          if (count == '0) begin
            result <= finalRes;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall/done handshake; combinational so KillE and reset take effect in the same cycle.
  always_comb begin
    StallReqE = 1'b0;
    DoneE     = 1'b0;
    case (state)
      IDLE:    StallReqE = StartE & ~KillE;
      RUN:     StallReqE = ~KillE;
      DONE:    DoneE     = ~KillE;
      default: ;
    endcase
    if (!rst_n) begin
      StallReqE = 1'b0;
      DoneE     = 1'b0;
    end
  end

  assign MulDivResultE = result;

endmodule
